uart_tx_arbiter: RTL and testbench

- Round-robin, packet-locking arbiter that shares the single RS232 UART transmit sink (Avalon-ST, 8-bit) between NUM_REQ byte-stream requesters.
- Placed between the requesters and the UART core's transmit sink.
- A grant is held until the owner transfers an end-of-packet byte or goes idle for TIMEOUT cycles, so messages from different requesters never interleave on TXD.

---
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin, packet-locking arbiter sharing one 8-bit Avalon-ST UART
// transmit sink between NUM_REQ byte-stream requesters. Once a requester
// owns the sink, it keeps it until it transfers an end-of-packet byte or
// stays idle for TIMEOUT consecutive cycles. This keeps packets from
// different requesters from interleaving on TXD.
//
// Ports:
//   clk_clk        system clock, rising edge
//   reset_reset    asynchronous active-high reset
//   req_data       requester bytes, requester i on [8i+7:8i]
//   req_valid      per-requester valid
//   req_eop        per-requester end-of-packet, qualified by valid
//   req_ready      per-requester ready (only the owner can see tx_ready)
//   tx_data        byte to the UART transmit sink
//   tx_valid       valid to the UART transmit sink
//   tx_error       error to the UART transmit sink, always 0
//   tx_ready       ready from the UART transmit sink
//   grant          one-hot current owner, zero when idle
//   busy           high while a requester owns the sink
//   timeout_pulse  one-cycle strobe after a forced release
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_eop,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 tx_error,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_pulse
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] idle_cnt;

    logic [IDX_W-1:0] next_idx;
    logic             any_valid;
    logic [IDX_W-1:0] owner_next;
    logic             xfer;

    // Rotating priority search starting at rr_ptr. Scanning from the far
    // end back toward rr_ptr lets the closest valid requester win.
    always_comb begin
        logic [IDX_W:0] sum;
        next_idx  = '0;
        any_valid = 1'b0;
        sum       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NUM_REQ))
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            if (req_valid[sum[IDX_W-1:0]]) begin
                next_idx  = sum[IDX_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

    // Owner pass-through. Everything is gated by the state register, so an
    // asynchronous reset silences the sink interface immediately.
    always_comb begin
        tx_data   = '0;
        tx_valid  = 1'b0;
        req_ready = '0;
        if (state == OWN) begin
            tx_data          = req_data[{owner, 3'b000} +: 8];
            tx_valid         = req_valid[owner];
            req_ready[owner] = tx_ready;
        end
    end

    assign xfer       = tx_valid & tx_ready;
    assign owner_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign busy       = (state == OWN);
    assign tx_error   = 1'b0;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state         <= IDLE;
            grant         <= '0;
            owner         <= '0;
            rr_ptr        <= '0;
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state    <= OWN;
                        owner    <= next_idx;
                        grant    <= NUM_REQ'(1) << next_idx;
                        idle_cnt <= '0;
                    end
                end
                OWN: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        // EOP wins outright; the counter was cleared by
                        // this transfer, so no timeout can be pending.
                        if (req_eop[owner]) begin
                            state  <= IDLE;
                            grant  <= '0;
                            rr_ptr <= owner_next;
                        end
                    end else if (!req_valid[owner]) begin
                        // idle_cnt holds the idle cycles already seen, so
                        // matching TIMEOUT-1 here ends the TIMEOUT-th one.
                        if (idle_cnt == CNT_W'(TIMEOUT - 1)) begin
                            state         <= IDLE;
                            grant         <= '0;
                            rr_ptr        <= owner_next;
                            idle_cnt      <= '0;
                            timeout_pulse <= 1'b1;
                        end else if (idle_cnt != '1) begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                    // Valid but stalled by the UART: hold, no idle count.
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 1024;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_eop;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_error;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_pulse;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .CNT_W(11)) dut (
        .clk_clk(clk), .reset_reset(rst),
        .req_data(req_data), .req_valid(req_valid), .req_eop(req_eop),
        .req_ready(req_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_error(tx_error),
        .tx_ready(tx_ready),
        .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Per-requester packet sources: {eop, byte} entries.
    logic [8:0] q [N][$];
    logic [7:0] seen [$];       // bytes accepted by the sink, in order
    int gap_pct = 0;            // chance a loaded source withholds valid
    int rdy_pct = 100;          // chance the sink is ready
    int own3_idle = 0;          // idle cycles seen while requester 3 owns
    int pulses = 0;

    // Reference model: who owns the sink, where the next search begins,
    // how many consecutive idle cycles the owner has accumulated.
    int m_owner = -1;
    int m_rr    = 0;
    int m_idle  = 0;
    bit m_pulse = 0;

    task automatic push_pkt(input int i, input int len, input logic [7:0] b0);
        for (int b = 0; b < len; b++)
            q[i].push_back({(b == len - 1), 8'(b0 + b)});
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) q[i].delete();
        seen.delete();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && $urandom_range(99, 0) >= gap_pct) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = q[i][0][7:0];
                req_eop[i]         = q[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'($urandom);
                req_eop[i]         = 1'($urandom);
            end
        end
        tx_ready = ($urandom_range(99, 0) < rdy_pct);
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_grant, e_ready;
        logic [7:0]   e_data;
        logic         e_valid;
        e_grant = '0; e_ready = '0; e_data = '0; e_valid = 1'b0;
        if (!rst && m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_data           = req_data[m_owner*8 +: 8];
            e_valid          = req_valid[m_owner];
            e_ready[m_owner] = tx_ready;
        end
        chk("grant",     32'(grant),     32'(e_grant));
        chk("busy",      32'(busy),      32'(m_owner >= 0 && !rst));
        chk("tx_valid",  32'(tx_valid),  32'(e_valid));
        chk("tx_data",   32'(tx_data),   32'(e_data));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("tmo_pulse", 32'(timeout_pulse), 32'(m_pulse && !rst));
        chk("tx_error",  32'(tx_error),  32'd0);
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_idle = 0; m_pulse = 0;
    endtask

    task automatic model_step();
        bit pulse_n = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_owner < 0) begin
            bit found = 0;
            for (int k = 0; k < N; k++) begin
                int j = (m_rr + k) % N;
                if (!found && req_valid[j]) begin
                    found = 1; m_owner = j; m_idle = 0;
                end
            end
        end else begin
            int o = m_owner;
            if (req_valid[o] && tx_ready) begin
                void'(q[o].pop_front());
                m_idle = 0;
                if (req_eop[o]) begin
                    m_owner = -1; m_rr = (o + 1) % N;
                end
            end else if (!req_valid[o]) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_owner = -1; m_rr = (o + 1) % N; m_idle = 0; pulse_n = 1;
                end
            end
        end
        m_pulse = pulse_n;
    endtask

    // One cycle: drive just after the edge, check and advance mid-cycle.
    task automatic tick();
        drive_inputs();
        @(negedge clk);
        check_outputs();
        if (tx_valid && tx_ready) seen.push_back(tx_data);
        if (grant == 4'b1000 && !req_valid[3]) own3_idle++;
        if (timeout_pulse) pulses++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_q();
        gap_pct = 0; rdy_pct = 100;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic chk_seen(input string tag, input logic [7:0] exp [$]);
        chk({tag, "_len"}, 32'(seen.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < seen.size(); i++)
            chk(tag, 32'(seen[i]), 32'(exp[i]));
    endtask

    initial begin
        rst = 1'b1; req_data = '0; req_valid = '0; req_eop = '0; tx_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Single requester, 3-byte packet, then fairness moves search to 2.
        push_pkt(1, 3, 8'h41);
        for (int c = 0; c < 6; c++) tick();
        chk_seen("single", '{8'h41, 8'h42, 8'h43});
        seen.delete();
        for (int i = 0; i < N; i++) push_pkt(i, 1, 8'hA0 + 8'(i));
        for (int c = 0; c < 8; c++) tick();
        chk_seen("after_single", '{8'hA2, 8'hA3, 8'hA0, 8'hA1});

        // Contention between 0 and 2; next search starts at 3.
        do_reset();
        push_pkt(0, 2, 8'h10);
        push_pkt(2, 2, 8'h20);
        for (int c = 0; c < 8; c++) tick();
        chk_seen("contend", '{8'h10, 8'h11, 8'h20, 8'h21});
        seen.delete();
        for (int i = 0; i < N; i++) push_pkt(i, 1, 8'hB0 + 8'(i));
        for (int c = 0; c < 8; c++) tick();
        chk_seen("after_contend", '{8'hB3, 8'hB0, 8'hB1, 8'hB2});

        // Long UART backpressure must not time out.
        do_reset();
        q[2].push_back({1'b0, 8'h55});
        q[2].push_back({1'b1, 8'h66});
        rdy_pct = 0;
        for (int c = 0; c < 2000; c++) tick();
        chk("bp_grant", 32'(grant), 32'h4);
        chk("bp_nodata", 32'(seen.size()), 32'd0);
        rdy_pct = 100;
        for (int c = 0; c < 3; c++) tick();
        chk_seen("bp", '{8'h55, 8'h66});

        // Timeout: requester 3 goes silent mid-packet; 0 waits.
        do_reset();
        q[3].push_back({1'b0, 8'h33});
        tick(); tick();
        push_pkt(0, 1, 8'h44);
        own3_idle = 0; pulses = 0;
        for (int c = 0; c < TO + 6; c++) tick();
        chk("tmo_idle_cycles", 32'(own3_idle), 32'(TO));
        chk("tmo_pulses", 32'(pulses), 32'd1);
        chk_seen("tmo", '{8'h33, 8'h44});

        // Round-robin with back-to-back single-byte packets.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_pkt(i, 1, 8'hC0 + 8'(i));
        for (int c = 0; c < 16; c++) tick();
        chk_seen("rr", '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC0, 8'hC1, 8'hC2, 8'hC3});

        // Asynchronous reset between edges, mid-packet.
        do_reset();
        push_pkt(1, 6, 8'h70);
        tick(); tick(); tick();
        drive_inputs();
        #2 rst = 1'b1;
        #1;
        chk("ar_tx_valid",  32'(tx_valid),  32'd0);
        chk("ar_grant",     32'(grant),     32'd0);
        chk("ar_busy",      32'(busy),      32'd0);
        chk("ar_req_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(posedge clk); #1;
        do_reset();
        for (int i = N - 1; i >= 0; i--) push_pkt(i, 1, 8'hD0 + 8'(i));
        for (int c = 0; c < 8; c++) tick();
        chk_seen("ar_restart", '{8'hD0, 8'hD1, 8'hD2, 8'hD3});

        // Randomized traffic with gaps and backpressure.
        do_reset();
        gap_pct = 15; rdy_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (q[i].size() == 0 && $urandom_range(3, 0) == 0)
                    push_pkt(i, int'($urandom_range(5, 1)), 8'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
